pingpong_fm_buffer: RTL

- Parametrised, single-clock, two-bank ping-pong buffer for input feature-map staging in front of the convolution PE array.
- The writer (feature-map loader) fills one bank while the reader (conv address generator) drains the other.
- Bank ownership is tracked by explicit done handshakes and full flags instead of an external switch level. Each side stalls automatically when its bank is not available.

---
 rtl/pingpong_fm_buffer_if.sv | 32 +++
 rtl/pingpong_fm_buffer.sv | 96 +++++++++
 2 files changed

// File: rtl/pingpong_fm_buffer_if.sv
// rtl/pingpong_fm_buffer_if.sv - writer/reader handshake bundle for the ping-pong feature-map buffer
// master drives accesses and done pulses; slave is the buffer.
interface pingpong_fm_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              i_wr_vld;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_wr_done;
  logic              o_wr_ready;
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_vld;
  logic              i_rd_done;
  logic              o_rd_ready;
  logic [1:0]        o_bank_sel;
  logic              o_addr_err;

  modport master (
    output i_wr_vld, i_wr_addr, i_wr_data, i_wr_done,
    output i_rd_en, i_rd_addr, i_rd_done,
    input  o_wr_ready, o_rd_data, o_rd_vld, o_rd_ready, o_bank_sel, o_addr_err
  );

  modport slave (
    input  i_wr_vld, i_wr_addr, i_wr_data, i_wr_done,
    input  i_rd_en, i_rd_addr, i_rd_done,
    output o_wr_ready, o_rd_data, o_rd_vld, o_rd_ready, o_bank_sel, o_addr_err
  );
endinterface

// File: rtl/pingpong_fm_buffer.sv
// rtl/pingpong_fm_buffer.sv - two-bank ping-pong feature-map buffer with done-handshake bank ownership
// Define PPB_OUT_REG_EN to add an output register stage (read latency 2).
module pingpong_fm_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  pingpong_fm_buffer_if.slave  bus
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:1][0:DEPTH-1];
  logic [1:0]        full;
  logic              wr_sel;
  logic              rd_sel;
  logic              addr_err;
  logic              rd_vld_q;
  logic [DATA_W-1:0] rd_data_q;

  logic wr_ready;
  logic rd_ready;
  logic wr_go;
  logic rd_go;
  logic wr_in;
  logic rd_in;

  assign wr_ready = !full[wr_sel];
  assign rd_ready = full[rd_sel];
  assign wr_go    = bus.i_wr_vld & wr_ready;
  assign rd_go    = bus.i_rd_en & rd_ready;
  assign wr_in    = {1'b0, bus.i_wr_addr} < DEPTH_L;
  assign rd_in    = {1'b0, bus.i_rd_addr} < DEPTH_L;

  // Bank storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_go && wr_in) begin
      mem[wr_sel][bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      full      <= 2'b00;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      addr_err  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if ((wr_go && !wr_in) || (rd_go && !rd_in)) begin
        addr_err <= 1'b1;
      end
      rd_vld_q <= rd_go & rd_in;
      if (rd_go && rd_in) begin
        rd_data_q <= mem[rd_sel][bus.i_rd_addr];
      end
      // The two done pulses can only ever hit opposite banks, so both apply.
      if (bus.i_wr_done && wr_ready) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (bus.i_rd_done && rd_ready) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

`ifdef PPB_OUT_REG_EN
  logic              rd_vld_q2;
  logic [DATA_W-1:0] rd_data_q2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_vld_q2  <= 1'b0;
      rd_data_q2 <= '0;
    end else begin
      rd_vld_q2  <= rd_vld_q;
      rd_data_q2 <= rd_data_q;
    end
  end

  assign bus.o_rd_vld  = rd_vld_q2;
  assign bus.o_rd_data = rd_data_q2;
`else
  assign bus.o_rd_vld  = rd_vld_q;
  assign bus.o_rd_data = rd_data_q;
`endif

  assign bus.o_wr_ready = wr_ready;
  assign bus.o_rd_ready = rd_ready;
  assign bus.o_bank_sel = {rd_sel, wr_sel};
  assign bus.o_addr_err = addr_err;
endmodule
